// File: rtl/m_tile_buffer.sv
// m_tile_buffer: on-chip matrix tile store fed by the matrix tile loader.
// Tiles are captured in row-major order during FILL. Once the loader signals
// completion the buffer enters READY. Random (row, tile) reads are served with
// one cycle of latency in every state, and each read is range-checked first.
// Optional build macro: TBUF_ZERO_DETECT_EN keeps a per-entry all-zero flag and
// adds the rd_zero and zero_tiles outputs, so downstream logic can skip padded tiles.
module m_tile_buffer #(
    parameter  int TILE_WIDTH     = 256,
    parameter  int DEPTH          = 64,
    localparam int BYTES_PER_TILE = TILE_WIDTH / 8,
    localparam int ADDR_W         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [9:0]            cols,
    input  logic [TILE_WIDTH-1:0] tile_data,
    input  logic                  tile_valid,
    input  logic                  load_done,
    output logic                  busy,
    output logic                  ready,
    output logic [ADDR_W:0]       tile_count,
    output logic                  overflow,
    input  logic                  rd_en,
    input  logic [9:0]            rd_row,
    input  logic [9:0]            rd_tile,
    output logic [TILE_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
`ifdef TBUF_ZERO_DETECT_EN
    output logic                  rd_zero,
    output logic [ADDR_W:0]       zero_tiles,
`endif
    output logic                  rd_err
);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY} state_t;

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [10:0]     BPT       = 11'(BYTES_PER_TILE);

    state_t                  state_q, state_d;
    logic [ADDR_W:0]         tile_count_q, tile_count_d;
    logic                    overflow_q, overflow_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic [10:0]             tpr_q, tpr_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_err_q, rd_err_d;
    logic [TILE_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic [TILE_WIDTH-1:0]   mem [DEPTH];

    logic                    filling;
    logic                    wr_en;
    logic                    drop;
    logic [ADDR_W-1:0]       wr_idx;
    logic [10:0]             tpr_calc;
    logic [20:0]             rd_addr;
    logic                    rd_oor;
    logic [ADDR_W-1:0]       rd_idx;

`ifdef TBUF_ZERO_DETECT_EN
    logic                    zflag [DEPTH];
    logic [ADDR_W:0]         zero_tiles_q, zero_tiles_d;
    logic                    rd_zero_q, rd_zero_d;
    logic                    wr_zero;
`endif

    // Write qualification, tiles-per-row and the read address/range check
    always_comb begin
        // A start overrides any tile strobe in the same cycle.
        filling  = (state_q == S_FILL) && !start;
        wr_en    = filling && tile_valid && (tile_count_q < DEPTH_CNT);
        drop     = filling && tile_valid && (tile_count_q == DEPTH_CNT);
        wr_idx   = tile_count_q[ADDR_W-1:0];
        tpr_calc = ({1'b0, cols} + BPT - 11'd1) / BPT;
        // The full 21-bit address is compared, so a large row cannot alias into range.
        rd_addr  = 21'(rd_row) * 21'(tpr_q) + 21'(rd_tile);
        // The check uses the pre-write count, so the entry being written is never read.
        rd_oor   = ({1'b0, rd_tile} >= tpr_q) || (rd_addr >= 21'(tile_count_q));
        rd_idx   = rd_addr[ADDR_W-1:0];
    end

    // Next-state, counter, flag and read-response computation
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        tile_count_d = tile_count_q;
        overflow_d   = overflow_q;
        tpr_d        = tpr_q;
        if (start) begin
            state_d      = S_FILL;
            tile_count_d = '0;
            overflow_d   = 1'b0;
            tpr_d        = tpr_calc;
        end else if (state_q == S_FILL) begin
            if (wr_en)     tile_count_d = tile_count_q + 1'b1;
            if (drop)      overflow_d   = 1'b1;
            if (load_done) state_d      = S_READY;
        end
        busy_d     = (state_d == S_FILL);
        ready_d    = (state_d == S_READY);
        rd_valid_d = rd_en;
        rd_err_d   = rd_en && rd_oor;
        rd_data_d  = rd_data_q;
        if (rd_en) rd_data_d = rd_oor ? '0 : mem[rd_idx];
    end

`ifdef TBUF_ZERO_DETECT_EN
    // Zero-tile count and per-read zero flag
    always_comb begin
        wr_zero      = (tile_data == '0);
        zero_tiles_d = zero_tiles_q;
        if (start)                  zero_tiles_d = '0;
        else if (wr_en && wr_zero)  zero_tiles_d = zero_tiles_q + 1'b1;
        rd_zero_d    = rd_en && !rd_oor && zflag[rd_idx];
    end
`endif

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            tile_count_q <= '0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            ready_q      <= 1'b0;
            tpr_q        <= '0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_data_q    <= '0;
`ifdef TBUF_ZERO_DETECT_EN
            zero_tiles_q <= '0;
            rd_zero_q    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            tile_count_q <= tile_count_d;
            overflow_q   <= overflow_d;
            busy_q       <= busy_d;
            ready_q      <= ready_d;
            tpr_q        <= tpr_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            rd_data_q    <= rd_data_d;
`ifdef TBUF_ZERO_DETECT_EN
            zero_tiles_q <= zero_tiles_d;
            rd_zero_q    <= rd_zero_d;
`endif
        end
    end

    // Tile array write
    // NOTE: the array has no reset. Entries at or above tile_count are never read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= tile_data;
    end

`ifdef TBUF_ZERO_DETECT_EN
    // Per-entry zero flag, written together with its tile
    always_ff @(posedge clk) begin
        if (wr_en) zflag[wr_idx] <= wr_zero;
    end

    assign rd_zero    = rd_zero_q;
    assign zero_tiles = zero_tiles_q;
`endif

    assign busy       = busy_q;
    assign ready      = ready_q;
    assign tile_count = tile_count_q;
    assign overflow   = overflow_q;
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_m_tile_buffer.sv
// Directed testbench for m_tile_buffer (TILE_WIDTH=256, DEPTH=64).
// Inputs are driven 1 time unit after each rising edge. Registered outputs are
// sampled at that same point. Define TBUF_ZERO_DETECT_EN to run the zero-flag checks.
module tb_m_tile_buffer;

    localparam int TW = 256;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [9:0]    cols;
    logic [TW-1:0] tile_data;
    logic          tile_valid;
    logic          load_done;
    logic          busy;
    logic          ready;
    logic [AW:0]   tile_count;
    logic          overflow;
    logic          rd_en;
    logic [9:0]    rd_row;
    logic [9:0]    rd_tile;
    logic [TW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_err;
`ifdef TBUF_ZERO_DETECT_EN
    logic          rd_zero;
    logic [AW:0]   zero_tiles;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        string      name;
        logic [9:0] row;
        logic [9:0] tile;
        logic       err;
        logic [7:0] b;
    } rd_vec_t;

    rd_vec_t vecs_a [7];
    rd_vec_t vecs_b [3];

    m_tile_buffer #(.TILE_WIDTH(256), .DEPTH(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cols       (cols),
        .tile_data  (tile_data),
        .tile_valid (tile_valid),
        .load_done  (load_done),
        .busy       (busy),
        .ready      (ready),
        .tile_count (tile_count),
        .overflow   (overflow),
        .rd_en      (rd_en),
        .rd_row     (rd_row),
        .rd_tile    (rd_tile),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
`ifdef TBUF_ZERO_DETECT_EN
        .rd_zero    (rd_zero),
        .zero_tiles (zero_tiles),
`endif
        .rd_err     (rd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [TW-1:0] rep(input logic [7:0] b);
        return {32{b}};
    endfunction

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] c);
        start = 1'b1;
        cols  = c;
        tick();
        start = 1'b0;
    endtask

    task automatic send_tile(input logic [TW-1:0] d);
        tile_valid = 1'b1;
        tile_data  = d;
        tick();
        tile_valid = 1'b0;
    endtask

    task automatic finish_load();
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [9:0] row, input logic [9:0] tile,
                            input logic err, input logic [7:0] b);
        rd_en   = 1'b1;
        rd_row  = row;
        rd_tile = tile;
        tick();
        rd_en   = 1'b0;
        check({name, ".valid"}, TW'(rd_valid), TW'(1'b1));
        check({name, ".err"},   TW'(rd_err),   TW'(err));
        check({name, ".data"},  rd_data,       err ? '0 : rep(b));
    endtask

    initial begin
        // tpr=2 and six tiles: entry n holds byte n.
        vecs_a[0] = '{"a_r2t1", 10'd2, 10'd1, 1'b0, 8'h05};
        vecs_a[1] = '{"a_r0t0", 10'd0, 10'd0, 1'b0, 8'h00};
        vecs_a[2] = '{"a_r2t0", 10'd2, 10'd0, 1'b0, 8'h04};
        vecs_a[3] = '{"a_r1t1", 10'd1, 10'd1, 1'b0, 8'h03};
        vecs_a[4] = '{"a_r0t2", 10'd0, 10'd2, 1'b1, 8'h00};
        vecs_a[5] = '{"a_r3t0", 10'd3, 10'd0, 1'b1, 8'h00};
        vecs_a[6] = '{"a_big",  10'd1023, 10'd1, 1'b1, 8'h00};
        // cols=40 gives tpr=2, tiles hold byte 0x10+n.
        vecs_b[0] = '{"b_r0t2", 10'd0, 10'd2, 1'b1, 8'h00};
        vecs_b[1] = '{"b_r5t0", 10'd5, 10'd0, 1'b1, 8'h00};
        vecs_b[2] = '{"b_r1t1", 10'd1, 10'd1, 1'b0, 8'h13};

        rst = 1'b1; start = 1'b0; cols = '0; tile_data = '0; tile_valid = 1'b0;
        load_done = 1'b0; rd_en = 1'b0; rd_row = '0; rd_tile = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy",     TW'(busy),       '0);
        check("rst.ready",    TW'(ready),      '0);
        check("rst.count",    TW'(tile_count), '0);
        check("rst.overflow", TW'(overflow),   '0);
        check("rst.rd_valid", TW'(rd_valid),   '0);
        check("rst.rd_err",   TW'(rd_err),     '0);
        check("rst.rd_data",  rd_data,         '0);
        rst = 1'b0;
        tick();

        // Basic fill and read
        do_start(10'd64);
        check("a.busy", TW'(busy), TW'(1'b1));
        for (int i = 0; i < 6; i++) send_tile(rep(8'(i)));
        // In FILL but not READY, so the load is not yet complete.
        check("a.ready_pre", TW'(ready), '0);
        finish_load();
        check("a.ready", TW'(ready),      TW'(1'b1));
        check("a.busy0", TW'(busy),       '0);
        check("a.count", TW'(tile_count), TW'(6));
        for (int i = 0; i < 7; i++)
            read_chk(vecs_a[i].name, vecs_a[i].row, vecs_a[i].tile, vecs_a[i].err, vecs_a[i].b);
        read_chk("a_hold_src", 10'd0, 10'd1, 1'b0, 8'h01);
        tick();
        check("a.idle_valid", TW'(rd_valid), '0);
        check("a.idle_err",   TW'(rd_err),   '0);
        check("a.idle_hold",  rd_data,       rep(8'h01));
        // Back-to-back reads
        rd_en = 1'b1; rd_row = 10'd0; rd_tile = 10'd0;
        tick();
        rd_row = 10'd2; rd_tile = 10'd1;
        check("b2b.0", rd_data, rep(8'h00));
        tick();
        rd_en = 1'b0;
        check("b2b.1", rd_data, rep(8'h05));

        // Partial-tile ceiling and range errors
        do_start(10'd40);
        for (int i = 0; i < 6; i++) send_tile(rep(8'(8'h10 + i)));
        finish_load();
        for (int i = 0; i < 3; i++)
            read_chk(vecs_b[i].name, vecs_b[i].row, vecs_b[i].tile, vecs_b[i].err, vecs_b[i].b);
        // cols=33 gives tpr=2, so tile 1 exists and tile 2 does not.
        do_start(10'd33);
        for (int i = 0; i < 4; i++) send_tile(rep(8'(8'h20 + i)));
        finish_load();
        read_chk("c33_r1t1", 10'd1, 10'd1, 1'b0, 8'h23);
        read_chk("c33_r0t2", 10'd0, 10'd2, 1'b1, 8'h00);

        // Overflow
        do_start(10'd64);
        for (int i = 0; i < 64; i++) send_tile(rep(8'(i)));
        check("ovf.count64", TW'(tile_count), TW'(64));
        check("ovf.flag0",   TW'(overflow),   '0);
        send_tile(rep(8'hEE));
        check("ovf.count", TW'(tile_count), TW'(64));
        check("ovf.flag",  TW'(overflow),   TW'(1'b1));
        finish_load();
        check("ovf.sticky", TW'(overflow), TW'(1'b1));
        read_chk("ovf_m63", 10'd31, 10'd1, 1'b0, 8'h3F);
        read_chk("ovf_m64", 10'd32, 10'd0, 1'b1, 8'h00);
        do_start(10'd64);
        check("ovf.clear", TW'(overflow),   '0);
        check("ovf.cnt0",  TW'(tile_count), '0);

        // tile_valid together with load_done on the 4th tile
        for (int i = 0; i < 3; i++) send_tile(rep(8'(8'h30 + i)));
        tile_valid = 1'b1; load_done = 1'b1; tile_data = rep(8'h33);
        tick();
        tile_valid = 1'b0; load_done = 1'b0;
        check("sim.count", TW'(tile_count), TW'(4));
        check("sim.ready", TW'(ready),      TW'(1'b1));
        read_chk("sim_r1t1", 10'd1, 10'd1, 1'b0, 8'h33);
        // Strobes in READY are ignored
        send_tile(rep(8'h99));
        check("rdy.ignore", TW'(tile_count), TW'(4));
        check("rdy.stay",   TW'(ready),      TW'(1'b1));
        // start together with tile_valid drops the tile
        start = 1'b1; cols = 10'd64; tile_valid = 1'b1; tile_data = rep(8'h77);
        tick();
        start = 1'b0; tile_valid = 1'b0;
        check("stv.count", TW'(tile_count), '0);
        check("stv.busy",  TW'(busy),       TW'(1'b1));
        read_chk("stv_r0t0", 10'd0, 10'd0, 1'b1, 8'h00);

        // Asynchronous reset in the middle of a fill
        for (int i = 0; i < 3; i++) send_tile(rep(8'(8'h40 + i)));
        read_chk("mid_r0t0", 10'd0, 10'd0, 1'b0, 8'h40);
        #2 rst = 1'b1;
        #1;
        check("mrst.busy",     TW'(busy),       '0);
        check("mrst.count",    TW'(tile_count), '0);
        check("mrst.rd_valid", TW'(rd_valid),   '0);
        @(negedge clk);
        rst = 1'b0;
        read_chk("mrst_r0t0", 10'd0, 10'd0, 1'b1, 8'h00);

`ifdef TBUF_ZERO_DETECT_EN
        // Zero-tile detection
        do_start(10'd64);
        send_tile(rep(8'h11));
        send_tile('0);
        send_tile(rep(8'h22));
        send_tile('0);
        finish_load();
        check("z.count", TW'(zero_tiles), TW'(2));
        rd_en = 1'b1; rd_row = 10'd0; rd_tile = 10'd1;
        tick();
        check("z.t1", TW'(rd_zero), TW'(1'b1));
        rd_tile = 10'd0;
        tick();
        check("z.t0", TW'(rd_zero), '0);
        rd_row = 10'd1; rd_tile = 10'd2;
        tick();
        rd_en = 1'b0;
        check("z.err", TW'(rd_zero), '0);
        do_start(10'd64);
        check("z.clear", TW'(zero_tiles), '0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/m_tile_buffer.md
Name: m_tile_buffer

Overview:
- On-chip matrix tile store directly downstream of the matrix tile loader.
- Captures each 256-bit tile on the loader's tile strobe, writing tiles in row-major order into an internal array.
- Signals when the complete matrix is resident, then serves random (row, tile) reads to the compute array with 1-cycle latency.

Parameters:
- TILE_WIDTH, 256, tile width in bits; multiple of 8. BYTES_PER_TILE = TILE_WIDTH/8 (derived).
- DEPTH, 64, number of tile entries. ADDR_W = $clog2(DEPTH) (derived).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin new matrix load; clears count and flags, latches cols.
- cols  in  10  columns per row; sampled only when start=1.
- tile_data  in  TILE_WIDTH  tile from loader.
- tile_valid  in  1  one-cycle strobe: tile_data valid.
- load_done  in  1  one-cycle strobe from loader: matrix complete.
- busy  out  1  high in FILL.
- ready  out  1  high in READY.
- tile_count  out  ADDR_W+1  tiles stored since last start.
- overflow  out  1  sticky: a tile was dropped because the buffer was full.
- rd_en  in  1  read request.
- rd_row  in  10  matrix row index.
- rd_tile  in  10  tile index within row.
- rd_data  out  TILE_WIDTH  read data.
- rd_valid  out  1  rd_data valid; asserted exactly one cycle after rd_en.
- rd_err  out  1  with rd_valid: request was out of range.

Behaviour:
- Reset values:
  - state IDLE.
  - busy, ready, overflow, rd_valid, rd_err = 0.
  - tile_count, rd_data = 0.
  - tpr register = 0.
  - Array contents are not cleared.
- tpr = ceil(cols/BYTES_PER_TILE), computed as (cols+BYTES_PER_TILE-1)/BYTES_PER_TILE in 11 bits and registered on start.
- States IDLE, FILL, READY:
  - start=1 in any state -> FILL next cycle. Same edge: tile_count<=0, overflow<=0, ready<=0, tpr latched.
  - FILL, tile_valid=1, tile_count<DEPTH: mem[tile_count]<=tile_data; tile_count++.
  - FILL, tile_valid=1, tile_count==DEPTH: tile dropped; overflow<=1 (sticky until start/rst).
  - FILL, load_done=1 -> READY.
  - FILL, tile_valid and load_done in the same cycle: the tile is written/counted, then READY.
  - tile_valid or load_done in IDLE or READY: ignored.
  - start together with tile_valid/load_done: start wins; the tile is dropped and the count restarts at 0.
- Read path, accepted in any state:
  - addr = rd_row*tpr + rd_tile, in 21 bits, no truncation before range checks.
  - Out of range when rd_tile >= tpr OR addr >= tile_count (tile_count value before this cycle's write).
  - Out of range: next cycle rd_valid=1, rd_err=1, rd_data=0.
  - In range: next cycle rd_valid=1, rd_err=0, rd_data=mem[addr].
  - Read and write to the same entry in one cycle cannot occur, because the range check excludes that entry.
  - rd_en=0: rd_valid=0, rd_err=0; rd_data holds its last value.
- Back-to-back reads every cycle are supported at full throughput.
- tile_count saturates at DEPTH; no wrap-around.
- Reset mid-FILL: immediate return to IDLE; tile_count=0. Any read is then out of range until the next fill.

Optional Feature:
- Macro TBUF_ZERO_DETECT_EN.
- Defined:
  - Adds a per-entry zero flag, written with each tile: 1 if tile_data==0.
  - Adds output rd_zero (1 bit), aligned with rd_valid: the flag of the read entry, 0 on rd_err.
  - Adds output zero_tiles (ADDR_W+1 bits): count of all-zero tiles stored since start. Cleared on start/rst.
  - Used to skip padded tiles downstream.
- Not defined: neither port exists; no flag storage.

Test Plan:
- Basic fill and read: start with cols=64 (tpr=2); 6 tiles with tile_data = index i replicated in each byte; then load_done.
  - Expect ready=1, tile_count=6.
  - rd (row 2, tile 1) -> next cycle rd_valid=1, rd_err=0, rd_data bytes all 0x05.
- Partial-tile ceiling and range error: cols=40 -> tpr=2.
  - rd (row 0, tile 2) -> rd_err=1, rd_data=0.
  - rd (row 5, tile 0) after 6 tiles -> rd_err=1.
- Overflow: DEPTH=64; 65 tile strobes.
  - Expect tile_count=64, overflow=1, mem[63] holds tile 63.
  - start clears overflow to 0.
- Simultaneous events:
  - tile_valid with load_done on the 4th tile -> tile_count=4, ready next cycle.
  - start with tile_valid -> tile_count=0, state FILL.
- Reset mid-fill after 3 tiles: async rst.
  - Expect busy=0, tile_count=0, rd_valid=0.
  - rd (row 0, tile 0) after release -> rd_err=1.
- TBUF_ZERO_DETECT_EN: 4 tiles with tiles 1 and 3 all zero.
  - Expect zero_tiles=2.
  - Read of tile 1 -> rd_zero=1; read of tile 0 -> rd_zero=0.
